// File: rtl/approx_pkg.sv
// approx_pkg: mode encodings and the partial-product column mask shared by the approximate multiplier.
package approx_pkg;

    localparam logic [1:0] MODE_EXACT = 2'd0;
    localparam logic [1:0] MODE_TRUNC = 2'd1;
    localparam logic [1:0] MODE_COMP  = 2'd2;
    localparam int MAX_PW = 64;

    // Bit c is set when product column c survives truncation of the k lowest columns.
    function automatic logic [MAX_PW-1:0] col_mask(input int k, input int width);
        int kc;
        kc = (k > 2*width-1) ? 2*width-1 : k;
        col_mask = '0;
        for (int c = 0; c < 2*width; c++) col_mask[c] = (c >= kc);
    endfunction

endpackage

// File: rtl/approx_mul_pipe_if.sv
// approx_mul_pipe_if: operand/product streaming handshake of the approximate multiplier.
interface approx_mul_pipe_if #(parameter int WIDTH = 8, parameter int KW = 4);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [1:0]           mode;
    logic [KW-1:0]        trunc_cols;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   p;

    modport master (output in_valid, a, b, mode, trunc_cols, out_ready,
                    input  in_ready, out_valid, p);
    modport slave  (input  in_valid, a, b, mode, trunc_cols, out_ready,
                    output in_ready, out_valid, p);
endinterface

// File: rtl/approx_pp_array.sv
// approx_pp_array: masked partial-product sum with optional constant compensation, combinational.
module approx_pp_array
    import approx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int KW    = 4
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [1:0]         mode,
    input  logic [KW-1:0]      k,
    output logic [2*WIDTH-1:0] p
);
    localparam int PW = 2*WIDTH;

    logic          approx;
    int            kc;
    logic [PW-1:0] mask;
    logic [PW-1:0] comp;

    // Reserved mode 3 falls through to exact, as does K=0 in either approximate mode.
    always_comb begin
        approx = (mode == MODE_TRUNC) || (mode == MODE_COMP);
        kc = approx ? ((int'(k) > PW-1) ? PW-1 : int'(k)) : 0;
        mask = PW'(col_mask(kc, WIDTH));
        comp = (mode == MODE_COMP && kc > 0) ? PW'(1) << (kc-1) : '0;
        p = comp;
        for (int i = 0; i < WIDTH; i++)
            for (int j = 0; j < WIDTH; j++)
                p = p + (PW'(a[i] & b[j] & mask[i+j]) << (i+j));
    end

endmodule

// File: rtl/approx_mul_pipe.sv
// approx_mul_pipe: pipelined approximate multiplier with valid/ready back-pressure and a saturating op counter.
module approx_mul_pipe
    import approx_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int STAGES  = 2,
    parameter int KW      = 4,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    approx_mul_pipe_if.slave   bus,
    output logic [COUNT_W-1:0] op_count
);
    localparam int PW = 2*WIDTH;

    logic              advance;
    logic [PW-1:0]     prod;
    logic [STAGES-1:0] vld;
    logic [PW-1:0]     pd [STAGES];

    approx_pp_array #(.WIDTH(WIDTH), .KW(KW)) u_pp (
        .a    (bus.a),
        .b    (bus.b),
        .mode (bus.mode),
        .k    (bus.trunc_cols),
        .p    (prod)
    );

    // One shared enable: the whole pipe moves or the whole pipe holds, bubbles included.
    assign advance       = ~vld[STAGES-1] | bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = vld[STAGES-1];
    assign bus.p         = pd[STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            for (int s = 0; s < STAGES; s++) pd[s] <= '0;
        end else if (advance) begin
            vld[0] <= bus.in_valid;
            pd[0]  <= prod;
            for (int s = 1; s < STAGES; s++) begin
                vld[s] <= vld[s-1];
                pd[s]  <= pd[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            op_count <= '0;
        else if (bus.in_valid && advance && op_count != '1)
            op_count <= op_count + COUNT_W'(1);
    end

endmodule

// File: tb/tb_approx_mul_pipe.sv
// tb_approx_mul_pipe: directed and randomized checks of approx_mul_pipe against a row-based arithmetic model.
module tb_approx_mul_pipe;
    localparam int W  = 8;
    localparam int PW = 2*W;
    localparam int S  = 2;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    logic [CW-1:0] op_count;
    int checks = 0, errors = 0, cyc = 0, exp_cnt = 0, n_out = 0;
    logic [PW-1:0] exp_q [$];
    int acc_q [$];
    logic lat_chk = 1'b0, held = 1'b0, fin = 1'b0;
    logic [PW-1:0] hold_p, last_p;

    always #5 clk = ~clk;

    approx_mul_pipe_if #(.WIDTH(W), .KW(4)) bus ();

    approx_mul_pipe #(.WIDTH(W), .STAGES(S), .KW(4), .COUNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .op_count (op_count)
    );

    // Row i of the product keeps only multiplier bits j with i+j >= K.
    function automatic logic [PW-1:0] ref_mul(input int a, input int b, input int m, input int k);
        int kc, sh;
        longint s;
        kc = (k > PW-1) ? PW-1 : k;
        if (m != 1 && m != 2) return PW'(a*b);
        s = 0;
        for (int i = 0; i < W; i++) begin
            sh = kc - i;
            if (sh < 0) sh = 0;
            if (sh > W) sh = W;
            if (((a >> i) & 1) == 1) s += longint'(((b >> sh) << sh)) << i;
        end
        if (m == 2 && kc > 0) s += longint'(1) << (kc-1);
        return PW'(s);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input int ia, input int ib, input int im, input int ik, input logic ordy);
        logic fout;
        bus.in_valid = v;
        bus.a = W'(ia);
        bus.b = W'(ib);
        bus.mode = 2'(im);
        bus.trunc_cols = 4'(ik);
        bus.out_ready = ordy;
        #1;
        chk("in_ready", 32'(bus.in_ready), 32'(!bus.out_valid || ordy));
        fin = v && bus.in_ready;
        fout = bus.out_valid && ordy;
        if (fout) begin
            chk("stale", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                chk("p", 32'(bus.p), 32'(exp_q[0]));
                if (lat_chk) chk("latency", cyc - acc_q[0], S);
                void'(exp_q.pop_front());
                void'(acc_q.pop_front());
                last_p = bus.p;
                n_out++;
            end
        end
        held = bus.out_valid && !ordy;
        hold_p = bus.p;
        if (fin) begin
            exp_q.push_back(ref_mul(ia, ib, im, ik));
            acc_q.push_back(cyc);
            if (exp_cnt < (1 << CW) - 1) exp_cnt++;
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("op_count", 32'(op_count), exp_cnt);
        if (held) begin
            chk("hold_valid", 32'(bus.out_valid), 1);
            chk("hold_p", 32'(bus.p), 32'(hold_p));
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 50 && exp_q.size() != 0; c++) step(1'b0, 0, 0, 0, 0, 1'b1);
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        int n, base, ra, rb, rm, rk;
        logic have;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.mode = '0;
        bus.trunc_cols = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_p", 32'(bus.p), 0);
        chk("rst_op_count", 32'(op_count), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        rst = 1'b0;

        lat_chk = 1'b1;
        step(1'b1, 255, 255, 0, 0, 1'b1);
        drain();
        chk("max_exact", 32'(last_p), 32'hFE01);

        step(1'b1, 15, 15, 1, 4, 1'b1);
        drain();
        chk("trunc_k4", 32'(last_p), 176);
        step(1'b1, 15, 15, 2, 4, 1'b1);
        drain();
        chk("comp_k4", 32'(last_p), 184);
        step(1'b1, 15, 15, 1, 0, 1'b1);
        drain();
        chk("trunc_k0", 32'(last_p), 225);
        step(1'b1, 255, 255, 2, 15, 1'b1);
        drain();
        chk("comp_wrap", 32'(last_p), 32'(ref_mul(255, 255, 2, 15)));
        lat_chk = 1'b0;

        base = n_out;
        n = 0;
        for (int c = 0; c < 40 && (n < 10 || exp_q.size() != 0); c++) begin
            step(n < 10, 17*n + 3, 200 - 9*n, n % 4, n, !(c >= 4 && c < 9));
            if (fin) n++;
        end
        chk("stream_out", n_out - base, 10);

        step(1'b1, 7, 9, 0, 0, 1'b1);
        step(1'b1, 11, 13, 0, 0, 1'b1);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        held = 1'b0;
        exp_q.delete();
        acc_q.delete();
        exp_cnt = 0;
        chk("flush_out_valid", 32'(bus.out_valid), 0);
        chk("flush_op_count", 32'(op_count), 0);
        repeat (5) step(1'b0, 0, 0, 0, 0, 1'b1);

        for (int i = 0; i < 20; i++) step(1'b1, i, i + 1, 0, 0, 1'b1);
        drain();
        chk("count_sat", 32'(op_count), 15);

        n = 0;
        have = 1'b0;
        for (int c = 0; c < 30000 && n < 10000; c++) begin
            if (!have) begin
                ra = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 255));
                rb = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 255));
                rm = $urandom_range(0, 3);
                rk = $urandom_range(0, 15);
                have = 1'b1;
            end
            step($urandom_range(0, 9) < 8, ra, rb, rm, rk, $urandom_range(0, 9) < 8);
            if (fin) begin
                have = 1'b0;
                n++;
            end
        end
        chk("sweep_ops", n, 10000);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
